adc_capture_ctrl: RTL and testbench

Write-side controller for the ADC sample buffer in the Electrochemical Workstation. Takes the 14-bit AD9244 data bus and fills the 256-entry ADC RAM at a programmable decimated rate. Drives the buffer's write address, write data and write enable, then raises `done` so the UART and FFT read paths can drain the frame. Sits between the AD9244 front end and the ADC RAM write port.

---
 rtl/adc_capture_ctrl_pkg.sv | 16 +
 rtl/adc_pace_div.sv | 32 +++
 rtl/adc_capture_ctrl.sv | 128 ++++++++++++
 tb/tb_adc_capture_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/adc_capture_ctrl_pkg.sv
// Shared definitions for the ADC capture path: buffer geometry and the
// capture state encoding used by the write-side controller.
package adc_capture_ctrl_pkg;

    localparam int ND_ADC      = 14;   // AD9244 sample width
    localparam int NA_ADC      = 8;    // ADC RAM address width
    localparam int N_DEPTH_ADC = 256;  // frame length, equals 2**NA_ADC
    localparam int DW_DECIM    = 16;   // decimation register width

    typedef enum logic [1:0] {
        CAP_IDLE = 2'd0,
        CAP_RUN  = 2'd1,
        CAP_DONE = 2'd2
    } cap_state_t;

endpackage

// File: rtl/adc_pace_div.sv
// Reloadable down-counter that paces the sample writes. The tick is high
// while enabled and the count has reached zero; the parent reloads it on
// every tick so writes land every (reload value + 1) cycles.
module adc_pace_div #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [DW-1:0] load_val,
    input  logic          en,
    output logic          tick
);

    logic [DW-1:0] cnt;

    assign tick = en && (cnt == '0);

    // Load has priority; otherwise count down toward zero while enabled.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - DW'(1);
        end
    end

endmodule

// File: rtl/adc_capture_ctrl.sv
// Write-side controller for the ADC sample buffer: registers the AD9244
// bus, writes one frame of DEPTH samples at a decimated rate, then holds
// done until the next start or an abort.
module adc_capture_ctrl
    import adc_capture_ctrl_pkg::*;
#(
    parameter int ND    = ND_ADC,
    parameter int NA    = NA_ADC,
    parameter int DEPTH = N_DEPTH_ADC,
    parameter int DW    = DW_DECIM
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [DW-1:0] decim,
    input  logic [ND-1:0] adc_data,
    input  logic          adc_otr,
    output logic          wr_en,
    output logic [NA-1:0] wr_addr,
    output logic [ND-1:0] wr_data,
    output logic          busy,
    output logic          done,
    output logic          ovr_flag,
    output logic [NA:0]   sample_cnt
);

    cap_state_t    state, state_next;
    logic [ND-1:0] adc_q;
    logic          otr_q;
    logic [DW-1:0] d_lat;
    logic          start_go;
    logic          pace_en;
    logic          tick;
    logic          frame_full;

    // The last write has been registered once the count reaches DEPTH; the
    // state moves to DONE one edge later, together with wr_en dropping.
    assign frame_full = (sample_cnt == (NA+1)'(DEPTH));

    assign busy = (state == CAP_RUN);
    assign done = (state == CAP_DONE);

    adc_pace_div #(.DW(DW)) u_pace (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (start_go || tick),
        .load_val (start_go ? '0 : d_lat),
        .en       (pace_en),
        .tick     (tick)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CAP_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; abort wins over start, start is ignored mid-frame.
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        start_go   = 1'b0;
        pace_en    = 1'b0;
        unique case (state)
            CAP_IDLE: begin
                if (start && !abort) begin
                    start_go   = 1'b1;
                    state_next = CAP_RUN;
                end
            end
            CAP_RUN: begin
                if (abort) begin
                    state_next = CAP_IDLE;
                end else if (frame_full) begin
                    state_next = CAP_DONE;
                end else begin
                    pace_en = 1'b1;
                end
            end
            CAP_DONE: begin
                if (abort) begin
                    state_next = CAP_IDLE;
                end else if (start) begin
                    start_go   = 1'b1;
                    state_next = CAP_RUN;
                end
            end
            default: state_next = CAP_IDLE;
        endcase
    end

    // Input register, frame setup on start, and one RAM write per tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adc_q      <= '0;
            otr_q      <= 1'b0;
            d_lat      <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            sample_cnt <= '0;
            ovr_flag   <= 1'b0;
        end else begin
            adc_q <= adc_data;
            otr_q <= adc_otr;
            wr_en <= tick;
            if (start_go) begin
                d_lat      <= decim;
                wr_addr    <= '0;
                sample_cnt <= '0;
                ovr_flag   <= 1'b0;
            end else if (tick) begin
                wr_addr    <= sample_cnt[NA-1:0];
                wr_data    <= adc_q;
                sample_cnt <= sample_cnt + (NA+1)'(1);
                if (otr_q) begin
                    ovr_flag <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Bench for adc_capture_ctrl: randomized sample data and decimation checked
// against a timing model derived from the frame rules (write i lands
// 1 + i*(decim+1) edges after start, carrying the sample taken one edge earlier).
module tb_adc_capture_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [15:0] decim;
    logic [13:0] adc_data;
    logic        adc_otr;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [13:0] wr_data;
    logic        busy;
    logic        done;
    logic        ovr_flag;
    logic [8:0]  sample_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int edge_n   = 0;
    logic [13:0] data_hist [int];

    adc_capture_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .decim      (decim),
        .adc_data   (adc_data),
        .adc_otr    (adc_otr),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .ovr_flag   (ovr_flag),
        .sample_cnt (sample_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge; remembers what the DUT sampled on adc_data there.
    task automatic step();
        @(posedge clk);
        edge_n++;
        data_hist[edge_n] = adc_data;
        #1;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({wr_en, wr_addr, wr_data, busy, done, ovr_flag, sample_cnt} !== '0)
            $display("FAIL reset_outputs: got we=%b addr=%0d data=%0h busy=%b done=%b ovr=%b cnt=%0d, expected all 0",
                     wr_en, wr_addr, wr_data, busy, done, ovr_flag, sample_cnt);
        else n_pass++;
    endtask

    // Runs one capture from start and checks every cycle against the model.
    // otr_idx: write index whose sample carries adc_otr (-1 none).
    // abort_at: abort once this many writes are done (-1 none).
    // mid_start_at: pulse start once this many writes are done (-1 none).
    task automatic capture_frame(input int d, input bit ramp, input int otr_idx,
                                 input int abort_at, input int mid_start_at);
        int ks, done_edge, abort_edge, nexp, rel, exp_idx;
        bit exp_we, exp_busy, exp_done, exp_ovr, mid_sent;
        decim    = 16'(d);
        adc_data = 14'($urandom);
        adc_otr  = 1'b0;
        start    = 1'b1;
        step();
        start = 1'b0;
        ks    = edge_n;
        n_checks++;
        if ({busy, done, ovr_flag, wr_en} !== 4'b1000 || sample_cnt !== 9'd0)
            $display("FAIL start_state: got busy=%b done=%b ovr=%b we=%b cnt=%0d, expected 1 0 0 0 cnt=0",
                     busy, done, ovr_flag, wr_en, sample_cnt);
        else n_pass++;
        decim      = 16'($urandom);
        done_edge  = ks + 2 + 255 * (d + 1);
        abort_edge = -1;
        nexp       = 0;
        mid_sent   = 1'b0;
        while (edge_n < done_edge + 3) begin
            adc_data = ramp ? 14'(edge_n + 1) : 14'($urandom);
            adc_otr  = (otr_idx >= 0) && (edge_n + 1 == ks + otr_idx * (d + 1));
            abort    = (abort_at >= 0) && (abort_edge < 0) && (nexp == abort_at);
            if (mid_start_at >= 0 && !mid_sent && nexp == mid_start_at) begin
                start    = 1'b1;
                mid_sent = 1'b1;
            end
            step();
            if (abort) abort_edge = edge_n;
            abort = 1'b0;
            start = 1'b0;
            rel     = edge_n - ks - 1;
            exp_idx = rel / (d + 1);
            exp_we  = (abort_edge < 0) && (rel >= 0) && (rel % (d + 1) == 0) && (exp_idx < 256);
            if (exp_we) nexp++;
            exp_busy = (abort_edge < 0) && (edge_n < done_edge);
            exp_done = (abort_edge < 0) && (edge_n >= done_edge);
            exp_ovr  = (otr_idx >= 0) && (nexp > otr_idx);
            n_checks++;
            if (wr_en !== exp_we)
                $display("FAIL wr_en @edge+%0d: got %b expected %b", edge_n - ks, wr_en, exp_we);
            else n_pass++;
            if (exp_we) begin
                n_checks++;
                if (wr_addr !== 8'(exp_idx) || wr_data !== data_hist[edge_n - 1])
                    $display("FAIL write_%0d: got addr=%0d data=%0h expected addr=%0d data=%0h",
                             exp_idx, wr_addr, wr_data, exp_idx, data_hist[edge_n - 1]);
                else n_pass++;
            end
            n_checks++;
            if (busy !== exp_busy || done !== exp_done)
                $display("FAIL busy_done @edge+%0d: got %b%b expected %b%b",
                         edge_n - ks, busy, done, exp_busy, exp_done);
            else n_pass++;
            n_checks++;
            if (sample_cnt !== 9'(nexp) || ovr_flag !== exp_ovr)
                $display("FAIL cnt_ovr @edge+%0d: got cnt=%0d ovr=%b expected cnt=%0d ovr=%b",
                         edge_n - ks, sample_cnt, ovr_flag, nexp, exp_ovr);
            else n_pass++;
            if (abort_edge >= 0 && edge_n >= abort_edge + 4) break;
        end
    endtask

    task automatic test_ramp_decim0();   capture_frame(0, 1'b1, -1, -1, -1);  endtask
    task automatic test_decim3();        capture_frame(3, 1'b0, -1, -1, -1);  endtask
    task automatic test_otr_sticky();    capture_frame(1, 1'b0, 5, -1, -1);   endtask
    task automatic test_mid_start();     capture_frame(2, 1'b0, -1, -1, 100); endtask
    task automatic test_abort_capture(); capture_frame(0, 1'b0, -1, 10, -1);  endtask

    // Abort out of DONE, then start+abort together from IDLE.
    task automatic test_abort_done();
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_checks++;
        if ({busy, done, wr_en, ovr_flag} !== 4'b0000 || sample_cnt !== 9'd256)
            $display("FAIL abort_from_done: got busy=%b done=%b we=%b ovr=%b cnt=%0d expected 0 0 0 0 cnt=256",
                     busy, done, wr_en, ovr_flag, sample_cnt);
        else n_pass++;
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        step();
        n_checks++;
        if ({busy, done, wr_en} !== 3'b000 || sample_cnt !== 9'd256)
            $display("FAIL start_abort_idle: got busy=%b done=%b we=%b cnt=%0d expected 0 0 0 cnt=256",
                     busy, done, wr_en, sample_cnt);
        else n_pass++;
    endtask

    // Reset asserted mid-frame at address 100, then a clean capture.
    task automatic test_reset_mid();
        decim = 16'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 101; i++) begin
            adc_data = 14'($urandom);
            step();
        end
        n_checks++;
        if (wr_addr !== 8'd100 || busy !== 1'b1)
            $display("FAIL pre_reset_addr: got addr=%0d busy=%b expected addr=100 busy=1", wr_addr, busy);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({wr_en, wr_addr, wr_data, busy, done, ovr_flag, sample_cnt} !== '0)
            $display("FAIL async_reset: got we=%b addr=%0d data=%0h busy=%b done=%b ovr=%b cnt=%0d expected all 0",
                     wr_en, wr_addr, wr_data, busy, done, ovr_flag, sample_cnt);
        else n_pass++;
        #2 rst_n = 1'b1;
        capture_frame(int'($urandom_range(0, 2)), 1'b0, -1, -1, -1);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        decim    = '0;
        adc_data = '0;
        adc_otr  = 1'b0;
        #3;
        test_reset();
        #9 rst_n = 1'b1;
        step();
        test_ramp_decim0();
        test_decim3();
        test_otr_sticky();
        test_mid_start();
        test_abort_done();
        test_abort_capture();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
